// File: rtl/ucode_issue_if.sv
// Fetch-side and ID-side valid/ready handshake bundle for the ucode issue sequencer.
interface ucode_issue_if;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        id_ready;

    modport slave (
        input  if_instr, if_valid, id_ready,
        output if_ready, id_instr, id_valid
    );

    modport master (
        output if_instr, if_valid, id_ready,
        input  if_ready, id_instr, id_valid
    );
endinterface

// File: rtl/ucode_issue_ctrl.sv
// Issue-side sequencer: passes instructions through a one-entry output slot and
// expands MUL Rd,Rs,#imm into MOV Rd,#0 followed by imm x ADD Rd,Rd,Rs.
module ucode_issue_ctrl #(
    parameter logic [6:0]  MUL_OPCODE = 7'b0110011,
    parameter logic [6:0]  MOV_OPCODE = 7'b0000000,
    parameter logic [6:0]  ADD_OPCODE = 7'b0110001,
    parameter logic [15:0] MAX_IMM    = 16'hFFFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    ucode_issue_if.slave  bus,
    output logic          ucode_active,
    output logic          mul_done,
    output logic          imm_clamped,
    output logic [15:0]   uop_count
);

    localparam logic [31:0] NOP = {5'b11001, 27'b0};

    // S_MOV is never resident: the MOV uop issues on the PASS accept itself.
    typedef enum logic [1:0] {
        S_PASS = 2'b00,
        S_ADD  = 2'b01,
        S_MOV  = 2'b10
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n, imm, cnt_init;
    logic [3:0]  rd_q, rs_q, rd_n, rs_n;
    logic [31:0] id_instr_q, load_instr;
    logic        id_valid_q, tag_q;
    logic        slot_free, accept, is_mul, clamp;
    logic        load, load_tag, hold, done_n, clamp_n;

    assign slot_free    = !id_valid_q || bus.id_ready;
    assign bus.if_ready = (state == S_PASS) && slot_free && !flush;
    assign accept       = bus.if_valid && bus.if_ready;
    assign is_mul       = (bus.if_instr[31:25] == MUL_OPCODE);
    assign imm          = bus.if_instr[15:0];
    assign clamp        = (imm > MAX_IMM);
    assign cnt_init     = clamp ? MAX_IMM : imm;

    assign bus.id_instr = id_instr_q;
    assign bus.id_valid = id_valid_q;
    assign ucode_active = (state == S_ADD) || (state == S_MOV);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        rd_n       = rd_q;
        rs_n       = rs_q;
        load       = 1'b0;
        load_tag   = 1'b0;
        load_instr = id_instr_q;
        hold       = 1'b0;
        done_n     = 1'b0;
        clamp_n    = 1'b0;
        case (state)
            S_PASS: begin
                if (accept) begin
                    load = 1'b1;
                    if (is_mul) begin
                        rd_n       = bus.if_instr[24:21];
                        rs_n       = bus.if_instr[20:17];
                        cnt_n      = cnt_init;
                        load_instr = {MOV_OPCODE, bus.if_instr[24:21], 5'b0, 16'b0};
                        load_tag   = 1'b1;
                        clamp_n    = clamp;
                        if (cnt_init == 16'd0) done_n  = 1'b1;
                        else                   state_n = S_ADD;
                    end else begin
                        load_instr = bus.if_instr;
                    end
                end
            end
            S_ADD: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_tag   = 1'b1;
                    load_instr = {ADD_OPCODE, rd_q, rd_q, rs_q, 13'b0};
                    cnt_n      = cnt - 16'd1;
                    if (cnt == 16'd1) begin
                        state_n = S_PASS;
                        done_n  = 1'b1;
                    end
                end
            end
            default: begin
                // Unreachable encodings recover to PASS without touching the slot.
                state_n = S_PASS;
                hold    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_PASS;
            cnt         <= 16'd0;
            rd_q        <= 4'd0;
            rs_q        <= 4'd0;
            id_instr_q  <= NOP;
            id_valid_q  <= 1'b0;
            tag_q       <= 1'b0;
            mul_done    <= 1'b0;
            imm_clamped <= 1'b0;
        end else if (flush) begin
            state       <= S_PASS;
            cnt         <= 16'd0;
            id_valid_q  <= 1'b0;
            tag_q       <= 1'b0;
            mul_done    <= 1'b0;
            imm_clamped <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            rd_q        <= rd_n;
            rs_q        <= rs_n;
            mul_done    <= done_n;
            imm_clamped <= clamp_n;
            if (load) begin
                id_instr_q <= load_instr;
                id_valid_q <= 1'b1;
                tag_q      <= load_tag;
            end else if (slot_free && !hold) begin
                id_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                 uop_count <= 16'd0;
        else if (id_valid_q && bus.id_ready && tag_q) uop_count <= uop_count + 16'd1;
    end

endmodule
